// File: rtl/ws2812_frame_driver_pkg.sv
// rtl/ws2812_frame_driver_pkg.sv - shared state encoding, default timing and colour reorder
package ws2812_frame_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    localparam int DEF_LED_COUNT    = 256;
    localparam int DEF_T0H_CYCLES   = 5;
    localparam int DEF_T1H_CYCLES   = 10;
    localparam int DEF_BIT_CYCLES   = 15;
    localparam int DEF_LATCH_CYCLES = 3600;

    localparam int PIXEL_W = 24;
    localparam int ADDR_W  = 9;

    // The strip expects green first; the decoder hands us {R,G,B}.
    function automatic logic [PIXEL_W-1:0] rgb_to_grb(input logic [PIXEL_W-1:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/led_frame_ram.sv
// rtl/led_frame_ram.sv - 512x24 simple dual-port frame memory, registered read
module led_frame_ram
    import ws2812_frame_driver_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [PIXEL_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [PIXEL_W-1:0] rdata
);

    logic [PIXEL_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ws2812_frame_driver.sv
// rtl/ws2812_frame_driver.sv - frame memory plus WS2812 serialiser for one LED data pin
module ws2812_frame_driver
    import ws2812_frame_driver_pkg::*;
#(
    parameter int LED_COUNT    = DEF_LED_COUNT,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic               clock_12mhz,
    input  logic               reset_n,
    input  logic               perform_write,
    input  logic [ADDR_W-1:0]  write_address,
    input  logic [PIXEL_W-1:0] write_data,
    output logic               led_data_out,
    output logic               frame_busy
);

    localparam int CYC_W = $clog2(BIT_CYCLES + 1);
    localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(LED_COUNT - 1);
    localparam logic [CYC_W-1:0]  BIT_LAST   = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0]  T0H_C      = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0]  T1H_C      = CYC_W'(T1H_CYCLES);
    localparam logic [LAT_W-1:0]  LATCH_LAST = LAT_W'(LATCH_CYCLES - 1);

    state_e               state_q, state_d;
    logic                 dirty_q, dirty_d, dirty_clr;
    logic [PIXEL_W-1:0]   shift_q, shift_d;
    logic [PIXEL_W-1:0]   next_pixel_q, next_pixel_d;
    logic [ADDR_W-1:0]    pixel_index_q, pixel_index_d;
    logic [4:0]           bit_index_q, bit_index_d;
    logic [CYC_W-1:0]     cycle_count_q, cycle_count_d;
    logic [LAT_W-1:0]     latch_count_q, latch_count_d;
    logic                 led_q, led_d;
    logic                 busy_pre_q, busy_q;
    logic                 write_ok;
    logic [ADDR_W-1:0]    raddr;
    logic [PIXEL_W-1:0]   rdata;

    assign write_ok = perform_write && ({1'b0, write_address} < (ADDR_W+1)'(LED_COUNT));

    // Address 0 while idle primes the frame; during SEND the port always
    // looks one pixel ahead and the value is sampled at the end of bit 23.
    assign raddr = (state_q == ST_IDLE) ? '0 : pixel_index_q + 9'd1;

    led_frame_ram u_ram (
        .clk   (clock_12mhz),
        .we    (write_ok),
        .waddr (write_address),
        .wdata (write_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_d       = state_q;
        dirty_clr     = 1'b0;
        shift_d       = shift_q;
        next_pixel_d  = next_pixel_q;
        pixel_index_d = pixel_index_q;
        bit_index_d   = bit_index_q;
        cycle_count_d = cycle_count_q;
        latch_count_d = latch_count_q;
        led_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dirty_q) begin
                    dirty_clr = 1'b1;
                    state_d   = ST_PRIME;
                end
            end
            ST_PRIME: begin
                shift_d       = rgb_to_grb(rdata);
                pixel_index_d = '0;
                bit_index_d   = 5'd23;
                cycle_count_d = '0;
                state_d       = ST_SEND;
            end
            ST_SEND: begin
                led_d = (cycle_count_q < (shift_q[23] ? T1H_C : T0H_C));
                if (bit_index_q == 5'd23 && cycle_count_q == BIT_LAST) begin
                    next_pixel_d = rdata;
                end
                if (cycle_count_q == BIT_LAST) begin
                    cycle_count_d = '0;
                    if (bit_index_q == 5'd0) begin
                        if (pixel_index_q == LAST_PIX) begin
                            latch_count_d = '0;
                            state_d       = ST_LATCH;
                        end else begin
                            shift_d       = rgb_to_grb(next_pixel_q);
                            pixel_index_d = pixel_index_q + 9'd1;
                            bit_index_d   = 5'd23;
                        end
                    end else begin
                        shift_d     = {shift_q[22:0], 1'b0};
                        bit_index_d = bit_index_q - 5'd1;
                    end
                end else begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (latch_count_q == LATCH_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    latch_count_d = latch_count_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A write in the clearing cycle must still buy one more frame.
        dirty_d = write_ok | (dirty_q & ~dirty_clr);
    end

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            dirty_q       <= 1'b0;
            shift_q       <= '0;
            next_pixel_q  <= '0;
            pixel_index_q <= '0;
            bit_index_q   <= '0;
            cycle_count_q <= '0;
            latch_count_q <= '0;
            led_q         <= 1'b0;
            busy_pre_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dirty_q       <= dirty_d;
            shift_q       <= shift_d;
            next_pixel_q  <= next_pixel_d;
            pixel_index_q <= pixel_index_d;
            bit_index_q   <= bit_index_d;
            cycle_count_q <= cycle_count_d;
            latch_count_q <= latch_count_d;
            led_q         <= led_d;
            // Two stages so busy rises on the same edge as the first data bit.
            busy_pre_q    <= (state_q != ST_IDLE);
            busy_q        <= busy_pre_q;
        end
    end

    assign led_data_out = led_q;
    assign frame_busy   = busy_q;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// tb/tb_ws2812_frame_driver.sv - self-checking bench decoding the LED waveform into frames
module tb_ws2812_frame_driver;

    localparam int LED       = 4;
    localparam int T0H       = 5;
    localparam int T1H       = 10;
    localparam int BITC      = 15;
    localparam int LAT       = 300;
    localparam int NBITS     = LED * 24;
    localparam int PIX_CYC   = 24 * BITC;
    localparam int FRAME_LEN = 1 + NBITS * BITC + LAT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pw = 1'b0;
    logic [8:0]  wa = '0;
    logic [23:0] wd = '0;
    logic        led, busy;

    ws2812_frame_driver #(
        .LED_COUNT(LED), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
        .BIT_CYCLES(BITC), .LATCH_CYCLES(LAT)
    ) dut (
        .clock_12mhz   (clk),
        .reset_n       (rst_n),
        .perform_write (pw),
        .write_address (wa),
        .write_data    (wd),
        .led_data_out  (led),
        .frame_busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [23:0] model [LED];

    // Frame monitor: collects one sample per clock while busy, decodes at the end.
    bit          samp[$];
    logic [23:0] fr_pix[$];
    int          fr_len[$], fr_shape[$], fr_rise[$], fr_gap[$];
    bit          in_frame = 1'b0;
    int          low_run = 0, cur_gap = 0, first_led = -1, stray = 0;

    function automatic void decode_frame();
        int errs, base, h;
        bit seen_low, v;
        logic [23:0] w;
        errs = 0;
        for (int p = 0; p < LED; p++) begin
            w = '0;
            for (int b = 0; b < 24; b++) begin
                base = (p * 24 + b) * BITC;
                h = 0;
                seen_low = 1'b0;
                for (int s = 0; s < BITC; s++) begin
                    v = (base + s < samp.size()) ? samp[base + s] : 1'b0;
                    if (v) begin
                        if (seen_low) errs++;
                        else h++;
                    end else begin
                        seen_low = 1'b1;
                    end
                end
                if (h == T1H) w = {w[22:0], 1'b1};
                else begin
                    w = {w[22:0], 1'b0};
                    if (h != T0H) errs++;
                end
            end
            fr_pix.push_back({w[15:8], w[23:16], w[7:0]});
        end
        for (int s = NBITS * BITC; s < samp.size(); s++) if (samp[s]) errs++;
        fr_len.push_back(samp.size());
        fr_shape.push_back(errs);
        fr_rise.push_back(first_led);
        fr_gap.push_back(cur_gap);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            low_run  = 0;
        end else if (busy) begin
            if (!in_frame) begin
                in_frame  = 1'b1;
                samp.delete();
                first_led = -1;
                cur_gap   = low_run;
            end
            if (led && first_led < 0) first_led = cyc;
            samp.push_back(led);
            low_run = 0;
        end else begin
            if (in_frame) begin
                in_frame = 1'b0;
                decode_frame();
            end
            if (led) stray++;
            low_run++;
        end
    end

    function automatic int pix_mism(input int k, input logic [23:0] e [LED]);
        int m;
        if (k < 0 || (k + 1) * LED > fr_pix.size()) return LED;
        m = 0;
        for (int p = 0; p < LED; p++) if (fr_pix[k * LED + p] !== e[p]) m++;
        return m;
    endfunction

    task automatic wr(input logic [8:0] a, input logic [23:0] d, output int wc);
        @(posedge clk); #1;
        pw = 1'b1; wa = a; wd = d;
        @(posedge clk); #1;
        wc = cyc;
        pw = 1'b0;
        if (a < LED) model[a] = d;
    endtask

    task automatic wait_idle();
        int quiet, n;
        quiet = 0; n = 0;
        while (quiet < 30 && n < 12000) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
            n++;
        end
        checks++;
        if (quiet < 30) begin
            failures++;
            $display("FAIL idle_timeout: busy still active after %0d cycles, required idle", n);
        end
    endtask

    task automatic wait_led_rise(output int r);
        int n;
        n = 0;
        r = -1;
        while (n < 100) begin
            @(negedge clk);
            if (led) begin r = cyc; break; end
            n++;
        end
        checks++;
        if (r < 0) begin
            failures++;
            $display("FAIL led_rise_timeout: no rise within %0d cycles, required a rise", n);
        end
    endtask

    task automatic test_reset();
        int act;
        repeat (5) @(negedge clk);
        checks++;
        if (led !== 1'b0) begin failures++; $display("FAIL reset_led: got %b required 0", led); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        rst_n = 1'b1;
        act = 0;
        repeat (10000) begin
            @(negedge clk);
            if (busy || led) act++;
        end
        checks++;
        if (act !== 0) begin failures++; $display("FAIL reset_quiet: active cycles %0d required 0", act); end
        checks++;
        if (fr_len.size() !== 0) begin failures++; $display("FAIL reset_frames: got %0d required 0", fr_len.size()); end
    endtask

    task automatic test_fill();
        int nf0;
        logic [23:0] d [LED];
        nf0 = fr_len.size();
        for (int i = 0; i < LED; i++) d[i] = 24'($urandom);
        @(posedge clk); #1;
        pw = 1'b1;
        for (int i = 0; i < LED; i++) begin
            wa = 9'(i); wd = d[i]; model[i] = d[i];
            @(posedge clk); #1;
        end
        pw = 1'b0;
        wait_idle();
        checks++;
        if (fr_len.size() - nf0 !== 2) begin failures++; $display("FAIL fill_frames: got %0d required 2", fr_len.size() - nf0); end
        for (int k = nf0; k < nf0 + 2; k++) begin
            checks++;
            if (pix_mism(k, model) !== 0) begin failures++; $display("FAIL fill_pixels: frame %0d bad pixels %0d required 0", k, pix_mism(k, model)); end
            checks++;
            if (k < fr_len.size() && (fr_len[k] !== FRAME_LEN || fr_shape[k] !== 0)) begin
                failures++;
                $display("FAIL fill_shape: len %0d shape_err %0d required %0d and 0", fr_len[k], fr_shape[k], FRAME_LEN);
            end
        end
        checks++;
        if (nf0 + 1 < fr_gap.size() && fr_gap[nf0 + 1] !== 1) begin failures++; $display("FAIL fill_gap: got %0d required 1", fr_gap[nf0 + 1]); end
    endtask

    task automatic test_single_write();
        int nf0, wc, k;
        logic [8:0]  a;
        logic [23:0] d;
        for (int it = 0; it < 3; it++) begin
            a = (it == 0) ? 9'd0 : 9'($urandom_range(0, LED - 1));
            d = (it == 0) ? 24'hFF0000 : 24'($urandom);
            nf0 = fr_len.size();
            wr(a, d, wc);
            wait_idle();
            k = nf0;
            checks++;
            if (fr_len.size() - nf0 !== 1) begin failures++; $display("FAIL single_frames: got %0d required 1", fr_len.size() - nf0); end
            if (k < fr_len.size()) begin
                checks++;
                if (fr_rise[k] !== wc + 3) begin failures++; $display("FAIL single_latency: rise at %0d required %0d", fr_rise[k], wc + 3); end
                checks++;
                if (fr_len[k] !== FRAME_LEN) begin failures++; $display("FAIL single_len: got %0d required %0d", fr_len[k], FRAME_LEN); end
                checks++;
                if (fr_shape[k] !== 0) begin failures++; $display("FAIL single_shape: errors %0d required 0", fr_shape[k]); end
                checks++;
                if (pix_mism(k, model) !== 0) begin failures++; $display("FAIL single_pixels: bad pixels %0d required 0", pix_mism(k, model)); end
            end
        end
    endtask

    task automatic test_out_of_range();
        int nf0, wc, act;
        nf0 = fr_len.size();
        wr(9'd300, 24'h123456, wc);
        wr(9'($urandom_range(LED, 511)), 24'($urandom), wc);
        act = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) act++;
        end
        checks++;
        if (act !== 0) begin failures++; $display("FAIL oor_busy: busy cycles %0d required 0", act); end
        checks++;
        if (fr_len.size() !== nf0) begin failures++; $display("FAIL oor_frames: got %0d required %0d", fr_len.size(), nf0); end
    endtask

    task automatic test_mid_frame_write();
        int nf0, wc, r;
        logic [23:0] e1 [LED];
        logic [23:0] d0, da, db;
        d0 = 24'($urandom); da = 24'($urandom); db = 24'($urandom);
        nf0 = fr_len.size();
        wr(9'd0, d0, wc);
        e1 = model;
        e1[2] = da;
        wait_led_rise(r);
        while (cyc < r + $urandom_range(20, 330)) @(posedge clk);
        wr(9'd2, da, wc);
        while (cyc < r + 2 * PIX_CYC + $urandom_range(0, 330)) @(posedge clk);
        wr(9'd0, db, wc);
        wait_idle();
        checks++;
        if (fr_len.size() - nf0 !== 2) begin failures++; $display("FAIL mid_frames: got %0d required 2", fr_len.size() - nf0); end
        checks++;
        if (pix_mism(nf0, e1) !== 0) begin failures++; $display("FAIL mid_first_pixels: bad pixels %0d required 0", pix_mism(nf0, e1)); end
        checks++;
        if (pix_mism(nf0 + 1, model) !== 0) begin failures++; $display("FAIL mid_second_pixels: bad pixels %0d required 0", pix_mism(nf0 + 1, model)); end
        checks++;
        if (nf0 + 1 < fr_shape.size() && fr_shape[nf0 + 1] !== 0) begin failures++; $display("FAIL mid_shape: errors %0d required 0", fr_shape[nf0 + 1]); end
    endtask

    task automatic test_back_to_back();
        int nf0, b;
        logic [23:0] d1, d2;
        d1 = 24'($urandom); d2 = 24'($urandom);
        b = $urandom_range(1, LED - 1);
        nf0 = fr_len.size();
        @(posedge clk); #1;
        pw = 1'b1; wa = 9'd0; wd = d1; model[0] = d1;
        @(posedge clk); #1;
        wa = 9'(b); wd = d2; model[b] = d2;
        @(posedge clk); #1;
        pw = 1'b0;
        wait_idle();
        checks++;
        if (fr_len.size() - nf0 !== 2) begin failures++; $display("FAIL b2b_frames: got %0d required 2", fr_len.size() - nf0); end
        checks++;
        if (nf0 + 1 < fr_gap.size() && fr_gap[nf0 + 1] !== 1) begin failures++; $display("FAIL b2b_gap: got %0d required 1", fr_gap[nf0 + 1]); end
        for (int k = nf0; k < nf0 + 2; k++) begin
            checks++;
            if (pix_mism(k, model) !== 0) begin failures++; $display("FAIL b2b_pixels: frame %0d bad pixels %0d required 0", k, pix_mism(k, model)); end
            checks++;
            if (k < fr_len.size() && fr_len[k] !== FRAME_LEN) begin failures++; $display("FAIL b2b_len: got %0d required %0d", fr_len[k], FRAME_LEN); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int nf0, wc, r, act;
        nf0 = fr_len.size();
        wr(9'd1, 24'($urandom), wc);
        wait_led_rise(r);
        while (cyc < r + 2 * PIX_CYC + BITC * $urandom_range(0, 23) + 1) @(negedge clk);
        checks++;
        if (led !== 1'b1) begin failures++; $display("FAIL rst_pre_led: got %b required 1", led); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_abort: led %b busy %b required 0 0", led, busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (2000) begin
            @(negedge clk);
            if (busy || led) act++;
        end
        checks++;
        if (act !== 0) begin failures++; $display("FAIL rst_quiet: active cycles %0d required 0", act); end
        checks++;
        if (fr_len.size() !== nf0) begin failures++; $display("FAIL rst_frames: got %0d required %0d", fr_len.size(), nf0); end
        wr(9'($urandom_range(0, LED - 1)), 24'($urandom), wc);
        wait_idle();
        checks++;
        if (pix_mism(nf0, model) !== 0) begin failures++; $display("FAIL rst_retained: bad pixels %0d required 0", pix_mism(nf0, model)); end
        checks++;
        if (stray !== 0) begin failures++; $display("FAIL stray_led: high cycles outside busy %0d required 0", stray); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single_write();
        test_out_of_range();
        test_mid_frame_write();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
